// File: rtl/mac_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mac_issue: issues LDS/STS/MUL/MAC/CLRMAC commands to the multiply unit,    |
// |            serialising exec ops ahead of reads (WAIT interlock).           |
// | Option: MAC_ISSUE_MACW_PAIR_EN enforces MAC.W SEL=01 before SEL=10.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mac_issue (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [3:0]  REQ_OP,
  input  logic [1:0]  REQ_SEL,
  input  logic        REQ_SAT,
  input  logic [27:0] REQ_A,
  input  logic [31:0] REQ_D,
  output logic        RSP_VALID,
  output logic [31:0] RSP_DATA,
  output logic        ERR,
  output logic [1:0]  MAC_SEL,
  output logic [3:0]  MAC_OP,
  output logic        MAC_S,
  output logic        MAC_WE,
  output logic [27:0] MU_A,
  output logic [31:0] MU_WD,
  input  logic [31:0] MU_RD,
  input  logic        MU_BUSY
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;
  localparam logic [1:0] c_ST_READ  = 2'd3;

  localparam logic [3:0] c_OP_LDS    = 4'b0000;
  localparam logic [3:0] c_OP_LDSP   = 4'b1000;
  localparam logic [3:0] c_OP_MULU   = 4'b0110;
  localparam logic [3:0] c_OP_MULS   = 4'b0111;
  localparam logic [3:0] c_OP_MACW   = 4'b1011;
  localparam logic [3:0] c_OP_STS    = 4'b0100;
  localparam logic [3:0] c_OP_CLRMAC = 4'b1111;

  logic [1:0]  state_q, state_d;
  logic [1:0]  mac_sel_q, mac_sel_d;
  logic [3:0]  mac_op_q, mac_op_d;
  logic        mac_s_q, mac_s_d;
  logic [27:0] mu_a_q, mu_a_d;
  logic [31:0] mu_wd_q, mu_wd_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        err_q, err_d;

  logic w_accept, w_adv, w_drop, w_known, w_need_sel, w_force_sel, w_is_sts;
  logic w_exec, w_pair_err;

  assign w_adv    = CE_R & ~MU_BUSY;
  assign w_accept = REQ_VALID & REQ_READY & CE_R;

  always_comb begin
    w_known     = 1'b0;
    w_need_sel  = 1'b0;
    w_force_sel = 1'b0;
    w_is_sts    = 1'b0;
    case (REQ_OP)
      c_OP_LDS, c_OP_LDSP, c_OP_MACW: begin
        w_known    = 1'b1;
        w_need_sel = 1'b1;
      end
      c_OP_STS: begin
        w_known    = 1'b1;
        w_need_sel = 1'b1;
        w_is_sts   = 1'b1;
      end
      c_OP_MULU, c_OP_MULS, c_OP_CLRMAC: begin
        w_known     = 1'b1;
        w_force_sel = 1'b1;
      end
      default: ;
    endcase
    w_drop = ~w_known | (w_need_sel & (REQ_SEL == 2'b00)) | w_pair_err;
  end

`ifdef MAC_ISSUE_MACW_PAIR_EN
  logic pair_q, pair_d;

  assign w_pair_err = (REQ_OP == c_OP_MACW) && (REQ_SEL == 2'b10) && !pair_q;

  always_comb begin
    pair_d = pair_q;
    if (w_accept && !w_drop && (REQ_OP == c_OP_MACW)) begin
      if (REQ_SEL == 2'b01)      pair_d = 1'b1;
      else if (REQ_SEL == 2'b10) pair_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) pair_q <= 1'b0;
    else     pair_q <= pair_d;
  end
`else
  assign w_pair_err = 1'b0;
`endif

  // Exec ops need one extra unit cycle to complete before the next request.
  assign w_exec = (mac_op_q == c_OP_MULU) || (mac_op_q == c_OP_MULS) ||
                  ((mac_op_q == c_OP_MACW) && (mac_sel_q == 2'b10));

  always_ff @(posedge CLK) begin
    if (RST) state_q <= c_ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE:  if (w_accept && !w_drop) state_d = w_is_sts ? c_ST_READ : c_ST_ISSUE;
      c_ST_ISSUE: if (w_adv) state_d = w_exec ? c_ST_WAIT : c_ST_IDLE;
      c_ST_WAIT:  if (w_adv) state_d = c_ST_IDLE;
      c_ST_READ:  if (w_adv) state_d = c_ST_IDLE;
      default:    state_d = c_ST_IDLE;
    endcase
  end

  always_comb begin
    REQ_READY = (state_q == c_ST_IDLE) && !MU_BUSY;
    MAC_WE    = (state_q == c_ST_ISSUE);
  end

  always_comb begin
    mac_sel_d   = mac_sel_q;
    mac_op_d    = mac_op_q;
    mac_s_d     = mac_s_q;
    mu_a_d      = mu_a_q;
    mu_wd_d     = mu_wd_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    err_d       = 1'b0;
    if (w_accept) begin
      if (w_drop) begin
        err_d = 1'b1;
      end else begin
        mac_op_d  = REQ_OP;
        mac_sel_d = w_force_sel ? 2'b11 : REQ_SEL;
        mac_s_d   = REQ_SAT;
        mu_a_d    = REQ_A;
        mu_wd_d   = REQ_D;
      end
    end
    if ((state_q == c_ST_READ) && w_adv) begin
      rsp_data_d  = MU_RD;
      rsp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mac_sel_q   <= 2'b00;
      mac_op_q    <= 4'b0000;
      mac_s_q     <= 1'b0;
      mu_a_q      <= 28'd0;
      mu_wd_q     <= 32'd0;
      rsp_data_q  <= 32'd0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      mac_sel_q   <= mac_sel_d;
      mac_op_q    <= mac_op_d;
      mac_s_q     <= mac_s_d;
      mu_a_q      <= mu_a_d;
      mu_wd_q     <= mu_wd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end

  assign MAC_SEL   = mac_sel_q;
  assign MAC_OP    = mac_op_q;
  assign MAC_S     = mac_s_q;
  assign MU_A      = mu_a_q;
  assign MU_WD     = mu_wd_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_VALID = rsp_valid_q;
  assign ERR       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mac_issue: directed bench with a transaction-level reference model.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mac_issue;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE_R = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic [3:0]  REQ_OP = 4'h0;
  logic [1:0]  REQ_SEL = 2'b00;
  logic        REQ_SAT = 1'b0;
  logic [27:0] REQ_A = 28'd0;
  logic [31:0] REQ_D = 32'd0;
  logic [31:0] MU_RD = 32'd0;
  logic        MU_BUSY = 1'b0;
  logic        REQ_READY, RSP_VALID, ERR, MAC_S, MAC_WE;
  logic [31:0] RSP_DATA, MU_WD;
  logic [1:0]  MAC_SEL;
  logic [3:0]  MAC_OP;
  logic [27:0] MU_A;

  mac_issue dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OP(REQ_OP), .REQ_SEL(REQ_SEL), .REQ_SAT(REQ_SAT), .REQ_A(REQ_A), .REQ_D(REQ_D),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .ERR(ERR),
    .MAC_SEL(MAC_SEL), .MAC_OP(MAC_OP), .MAC_S(MAC_S), .MAC_WE(MAC_WE),
    .MU_A(MU_A), .MU_WD(MU_WD), .MU_RD(MU_RD), .MU_BUSY(MU_BUSY)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;
  bit chk_en = 1'b0;

  // Reference model: outstanding work items plus the last forwarded command.
  logic        m_we, m_wait, m_read, m_exec, m_rsp_valid, m_err, m_s;
  logic [1:0]  m_sel;
  logic [3:0]  m_op;
  logic [27:0] m_a;
  logic [31:0] m_wd, m_rsp;
`ifdef MAC_ISSUE_MACW_PAIR_EN
  logic        m_pair;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    logic ok;
    m_rsp_valid = 1'b0;
    m_err       = 1'b0;
    if (RST) begin
      m_we = 0; m_wait = 0; m_read = 0; m_exec = 0; m_s = 0;
      m_sel = 0; m_op = 0; m_a = 0; m_wd = 0; m_rsp = 0;
`ifdef MAC_ISSUE_MACW_PAIR_EN
      m_pair = 0;
`endif
    end else if (CE_R && !MU_BUSY) begin
      if (m_read) begin
        m_rsp = MU_RD; m_rsp_valid = 1'b1; m_read = 1'b0;
      end else if (m_we) begin
        m_we = 1'b0; m_wait = m_exec;
      end else if (m_wait) begin
        m_wait = 1'b0;
      end else if (REQ_VALID) begin
        case (REQ_OP)
          4'b0000, 4'b1000, 4'b0100, 4'b1011: ok = (REQ_SEL != 2'b00);
          4'b0110, 4'b0111, 4'b1111:          ok = 1'b1;
          default:                            ok = 1'b0;
        endcase
`ifdef MAC_ISSUE_MACW_PAIR_EN
        if (REQ_OP == 4'b1011 && REQ_SEL == 2'b10 && !m_pair) ok = 1'b0;
`endif
        if (!ok) begin
          m_err = 1'b1;
        end else begin
          m_op = REQ_OP; m_s = REQ_SAT; m_a = REQ_A; m_wd = REQ_D;
          m_sel  = (REQ_OP inside {4'b0110, 4'b0111, 4'b1111}) ? 2'b11 : REQ_SEL;
          m_exec = (REQ_OP inside {4'b0110, 4'b0111}) ||
                   (REQ_OP == 4'b1011 && REQ_SEL == 2'b10);
          if (REQ_OP == 4'b0100) m_read = 1'b1;
          else                   m_we   = 1'b1;
`ifdef MAC_ISSUE_MACW_PAIR_EN
          if (REQ_OP == 4'b1011 && REQ_SEL == 2'b01) m_pair = 1'b1;
          if (REQ_OP == 4'b1011 && REQ_SEL == 2'b10) m_pair = 1'b0;
`endif
        end
      end
    end
  end

  always @(posedge CLK)
    if (!RST && MAC_WE && CE_R && !MU_BUSY) we_cnt++;

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("m_ready",     32'(REQ_READY), 32'(!(m_we || m_wait || m_read) && !MU_BUSY));
      chk("m_mac_we",    32'(MAC_WE),    32'(m_we));
      chk("m_mac_sel",   32'(MAC_SEL),   32'(m_sel));
      chk("m_mac_op",    32'(MAC_OP),    32'(m_op));
      chk("m_mac_s",     32'(MAC_S),     32'(m_s));
      chk("m_mu_a",      32'(MU_A),      32'(m_a));
      chk("m_mu_wd",     MU_WD,          m_wd);
      chk("m_rsp_valid", 32'(RSP_VALID), 32'(m_rsp_valid));
      chk("m_rsp_data",  RSP_DATA,       m_rsp);
      chk("m_err",       32'(ERR),       32'(m_err));
    end
  end

  task automatic tick();
    @(posedge CLK); #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Returns at 2ns after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [1:0] sel, input logic sat,
                      input logic [27:0] a, input logic [31:0] d);
    bit done = 1'b0;
    REQ_VALID = 1'b1; REQ_OP = op; REQ_SEL = sel; REQ_SAT = sat; REQ_A = a; REQ_D = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      done = REQ_READY && CE_R;
      tick();
    end
    REQ_VALID = 1'b0;
    if (!done) chk("send_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    idle(2);
    chk_en = 1'b1;
    @(negedge CLK);
    chk("rst_ready",    32'(REQ_READY), 32'd1);
    chk("rst_we",       32'(MAC_WE),    32'd0);
    chk("rst_wd",       MU_WD,          32'd0);
    chk("rst_rsp_data", RSP_DATA,       32'd0);
    tick();
    RST = 1'b0;
    tick();

    // LDS MACL
    w0 = we_cnt;
    send(4'b0000, 2'b01, 1'b0, 28'h0, 32'h12345678);
    @(negedge CLK);
    chk("lds_we", 32'(MAC_WE), 32'd1);
    chk("lds_sel", 32'(MAC_SEL), 32'h1);
    chk("lds_wd", MU_WD, 32'h12345678);
    chk("lds_ready_low", 32'(REQ_READY), 32'd0);
    tick();
    @(negedge CLK);
    chk("lds_we_drop", 32'(MAC_WE), 32'd0);
    chk("lds_ready_back", 32'(REQ_READY), 32'd1);
    chk("lds_pulses", 32'(we_cnt - w0), 32'd1);
    tick();

    // MULS.W then STS MACL
    send(4'b0111, 2'b01, 1'b1, 28'h10, 32'hFFFE0003);
    @(negedge CLK);
    chk("muls_sel", 32'(MAC_SEL), 32'h3);
    chk("muls_op", 32'(MAC_OP), 32'h7);
    chk("muls_we", 32'(MAC_WE), 32'd1);
    tick();
    @(negedge CLK);
    chk("muls_wait_we", 32'(MAC_WE), 32'd0);
    chk("muls_wait_ready", 32'(REQ_READY), 32'd0);
    tick();
    @(negedge CLK);
    chk("muls_ready_3", 32'(REQ_READY), 32'd1);
    tick();
    MU_RD = 32'hFFFFFFFA;
    send(4'b0100, 2'b01, 1'b0, 28'h0, 32'h0);
    @(negedge CLK);
    chk("sts_read_we", 32'(MAC_WE), 32'd0);
    chk("sts_read_rv", 32'(RSP_VALID), 32'd0);
    tick();
    MU_RD = 32'h0;
    @(negedge CLK);
    chk("sts_rv", 32'(RSP_VALID), 32'd1);
    chk("sts_data", RSP_DATA, 32'hFFFFFFFA);
    tick();
    @(negedge CLK);
    chk("sts_rv_drop", 32'(RSP_VALID), 32'd0);
    chk("sts_data_hold", RSP_DATA, 32'hFFFFFFFA);
    tick();

    // MAC.W SEL=10 with no prior SEL=01
    RST = 1'b1; tick(); RST = 1'b0; tick();
    send(4'b1011, 2'b10, 1'b0, 28'h2, 32'h0);
    @(negedge CLK);
`ifdef MAC_ISSUE_MACW_PAIR_EN
    chk("macw_err", 32'(ERR), 32'd1);
    chk("macw_no_we", 32'(MAC_WE), 32'd0);
`else
    chk("macw_err", 32'(ERR), 32'd0);
    chk("macw_we", 32'(MAC_WE), 32'd1);
    chk("macw_a", 32'(MU_A), 32'h2);
`endif
    idle(4);
    send(4'b1011, 2'b01, 1'b0, 28'h3, 32'h0);
    idle(2);
    send(4'b1011, 2'b10, 1'b1, 28'h4, 32'h0);
    @(negedge CLK);
    chk("macw_pair_we", 32'(MAC_WE), 32'd1);
    chk("macw_pair_err", 32'(ERR), 32'd0);
    idle(4);

    // ISSUE held through MU_BUSY and CE_R gaps
    w0 = we_cnt;
    send(4'b0000, 2'b10, 1'b0, 28'h5, 32'hA5A5A5A5);
    MU_BUSY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      CE_R = (i % 2 == 1);
      @(negedge CLK);
      chk("busy_we_hold", 32'(MAC_WE), 32'd1);
      tick();
    end
    MU_BUSY = 1'b0; CE_R = 1'b0;
    @(negedge CLK);
    chk("ce_we_hold", 32'(MAC_WE), 32'd1);
    tick();
    CE_R = 1'b1;
    @(negedge CLK);
    chk("ce_we_last", 32'(MAC_WE), 32'd1);
    tick();
    @(negedge CLK);
    chk("busy_we_drop", 32'(MAC_WE), 32'd0);
    chk("busy_pulses", 32'(we_cnt - w0), 32'd1);
    tick();

    // Reset during WAIT after MULU.W
    send(4'b0110, 2'b01, 1'b0, 28'h7, 32'h00030004);
    tick();
    RST = 1'b1;
    @(negedge CLK);
    chk("wait_we", 32'(MAC_WE), 32'd0);
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk("rstw_ready", 32'(REQ_READY), 32'd1);
    chk("rstw_sel", 32'(MAC_SEL), 32'd0);
    chk("rstw_op", 32'(MAC_OP), 32'd0);
    chk("rstw_wd", MU_WD, 32'd0);
    chk("rstw_a", 32'(MU_A), 32'd0);
    chk("rstw_rsp", RSP_DATA, 32'd0);
    tick();

    // Reset coinciding with a request
    w0 = we_cnt;
    RST = 1'b1; REQ_VALID = 1'b1; REQ_OP = 4'b0000; REQ_SEL = 2'b01; REQ_D = 32'h1;
    tick();
    RST = 1'b0; REQ_VALID = 1'b0;
    @(negedge CLK);
    chk("rstacc_we", 32'(MAC_WE), 32'd0);
    tick();
    @(negedge CLK);
    chk("rstacc_pulses", 32'(we_cnt - w0), 32'd0);
    tick();

    // Illegal op / SEL=00
    send(4'b0101, 2'b01, 1'b0, 28'h9, 32'hDEADBEEF);
    @(negedge CLK);
    chk("ill_err", 32'(ERR), 32'd1);
    chk("ill_we", 32'(MAC_WE), 32'd0);
    chk("ill_ready", 32'(REQ_READY), 32'd1);
    tick();
    @(negedge CLK);
    chk("ill_err_drop", 32'(ERR), 32'd0);
    tick();
    send(4'b0000, 2'b00, 1'b0, 28'h1, 32'h1);
    @(negedge CLK);
    chk("lds_sel0_err", 32'(ERR), 32'd1);
    tick();
    send(4'b0100, 2'b00, 1'b0, 28'h1, 32'h1);
    @(negedge CLK);
    chk("sts_sel0_err", 32'(ERR), 32'd1);
    tick();

    // STS frozen by CE_R and MU_BUSY; capture at the first qualifying edge
    MU_RD = 32'h11111111;
    send(4'b0100, 2'b10, 1'b0, 28'h0, 32'h0);
    CE_R = 1'b0; MU_RD = 32'h22222222;
    tick();
    CE_R = 1'b1; MU_BUSY = 1'b1; MU_RD = 32'h33333333;
    tick();
    MU_BUSY = 1'b0; MU_RD = 32'h44444444;
    @(negedge CLK);
    chk("stsf_rv", 32'(RSP_VALID), 32'd0);
    chk("stsf_sel", 32'(MAC_SEL), 32'h2);
    tick();
    @(negedge CLK);
    chk("stsf_rv1", 32'(RSP_VALID), 32'd1);
    chk("stsf_data", RSP_DATA, 32'h44444444);
    tick();

    // Mixed sequence, checked by the model every cycle
    MU_RD = 32'h0BADF00D;
    send(4'b1000, 2'b10, 1'b1, 28'hABCDEF1, 32'h01020304);
    send(4'b1111, 2'b00, 1'b0, 28'h0, 32'h0);
    CE_R = 1'b0; tick(); CE_R = 1'b1;
    send(4'b0110, 2'b10, 1'b0, 28'h2, 32'h7FFF8000);
    send(4'b0100, 2'b10, 1'b0, 28'h0, 32'h0);
    send(4'b1110, 2'b01, 1'b0, 28'h0, 32'h0);
    send(4'b0100, 2'b11, 1'b0, 28'h0, 32'h0);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_issue.md
MAC_ISSUE -- requirements
Module: mac_issue

Interface
REQ-001 Port CLK  in  1  system clock; all state updates on rising edge.
REQ-002 Port RST  in  1  reset, synchronous and active-high.
REQ-003 Port CE_R  in  1  clock enable shared with the multiply unit; state advances only in cycles where CE_R=1.
REQ-004 Ports REQ_VALID in 1, REQ_READY out 1  request handshake; transfer when VALID & READY & CE_R.
REQ-005 Port REQ_OP  in  4  op code: 0000 LDS, 1000 LDS @Rm+, 0110 MULU.W, 0111 MULS.W, 1011 MAC.W, 0100 STS, 1111 CLRMAC.
REQ-006 Port REQ_SEL  in  2  target: 01 MACL/operand A, 10 MACH/operand B.
REQ-007 Ports REQ_SAT in 1, REQ_A in 28, REQ_D in 32  saturation flag, operand address, write data.
REQ-008 Ports RSP_VALID out 1, RSP_DATA out 32, ERR out 1  STS read result and one-cycle error pulse.
REQ-009 Ports MAC_SEL out 2, MAC_OP out 4, MAC_S out 1, MAC_WE out 1  command to the multiply unit.
REQ-010 Ports MU_A out 28, MU_WD out 32, MU_RD in 32, MU_BUSY in 1  unit address, write data, read data, busy.

Function
REQ-011 States: IDLE, ISSUE, WAIT, READ; REQ_READY=1 only in IDLE with MU_BUSY=0.
REQ-012 On accept: REQ_OP, REQ_SEL, REQ_SAT, REQ_A and REQ_D are registered onto MAC_OP, MAC_SEL, MAC_S, MU_A and MU_WD; next state is ISSUE (write ops) or READ (STS).
REQ-013 MAC_SEL is forced to 11 for CLRMAC and for MULU.W/MULS.W; it is passed through for all other ops.
REQ-014 ISSUE: MAC_WE=1; when CE_R=1 and MU_BUSY=0, MAC_WE drops next cycle, so exactly one CE_R-qualified write pulse is issued per request.
REQ-015 Exec ops (MULx.W; MAC.W with SEL=10) go ISSUE->WAIT; all other write ops go ISSUE->IDLE.
REQ-016 WAIT lasts exactly one CE_R cycle (the unit completes its result), then goes to IDLE; interlock latency from accept to READY is 3 CE_R cycles.
REQ-017 READ: MAC_WE=0 and MAC_SEL is driven; at the first CE_R with MU_BUSY=0, MU_RD is captured into RSP_DATA, RSP_VALID pulses for 1 CLK, then the state goes to IDLE.
REQ-018 STS after any exec op observes the completed result, because WAIT serialises the two.
REQ-019 MU_BUSY=1 freezes state and all outputs; CE_R=0 likewise.
REQ-020 An unlisted REQ_OP, or SEL=00 on LDS/STS/MAC.W, is accepted and dropped: no unit command, ERR pulses 1 CLK, and the state stays IDLE.
REQ-021 RSP_DATA holds its value until the next STS completes.
REQ-022 Simultaneous RST and an accept: RST wins, and the request is lost.

Reset
REQ-023 RST=1: state IDLE; MAC_SEL=00, MAC_OP=0000, MAC_S=0, MAC_WE=0, MU_A=0, MU_WD=0, RSP_VALID=0, RSP_DATA=0, ERR=0, and the pair flag is cleared.
REQ-024 RST during ISSUE/WAIT/READ aborts the op; MAC_WE=0 from the next cycle, and no RSP_VALID or ERR is produced.

Configuration
REQ-025 Macro MAC_ISSUE_MACW_PAIR_EN, when defined: a pair flag is set by a MAC.W SEL=01 issue and cleared by a MAC.W SEL=10 issue; a MAC.W SEL=10 request with the flag clear is dropped with an ERR pulse.
REQ-026 Macro undefined: no pair flag, every MAC.W is forwarded, and only REQ-020 errors exist.

Verification
REQ-027 LDS, SEL=01, D=0x12345678, CE_R=1 constant -> one MAC_WE pulse with MAC_SEL=01, MU_WD=0x12345678; READY returns 2 cycles after accept.
REQ-028 MULS.W, D=0xFFFE0003 -> MAC_SEL=11, MAC_OP=0111, one WE pulse, WAIT 1 cycle; a following STS SEL=01 with MU_RD model returning 0xFFFFFFFA gives RSP_DATA=0xFFFFFFFA, RSP_VALID 1 cycle.
REQ-029 MAC.W, A=0x0000002, SEL=10 with no prior SEL=01 -> with macro: no WE, ERR=1 for 1 cycle; without macro: WE issued, ERR=0.
REQ-030 CE_R toggling 1/0 and MU_BUSY=1 for 3 cycles during ISSUE -> MAC_WE held high until MU_BUSY=0 and CE_R=1, still exactly one qualified write.
REQ-031 RST asserted in WAIT after MULU.W -> all outputs zero next cycle, READY=1, and no RSP_VALID or ERR.
REQ-032 REQ_OP=0101 -> ERR pulse, MAC_WE never asserted, READY stays 1.
